// File: rtl/bootrom_stream_loader.sv
// ---------------------------------------------------------------------------
// bootrom_stream_loader
//
// Purpose:
//   Boot loader in front of the ZPU boot memory's writable port B. It takes a
//   framed image from a valid/ready byte stream (UART/SPI front end),
//   assembles big-endian words and writes each word into the dual-port RAM.
//   The CPU is held in reset while a load is in progress and is released only
//   when the load completes successfully.
//
//   Frame: MAGIC, N[15:8], N[7:0], N*BYTES data bytes[, checksum byte].
//
// Optional feature (macro LOADER_CHECKSUM_EN):
//   When defined, a trailing checksum byte is expected. The 8-bit modulo-256
//   sum of LEN_HI, LEN_LO, all data bytes and the checksum byte must be zero;
//   otherwise the load ends in ERR and the CPU stays held. When undefined, the
//   frame ends after the last data byte and no checksum register exists.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   start     in   one-cycle pulse that arms the loader (IDLE/DONE/ERR only)
//   s_data    in   stream byte
//   s_valid   in   stream byte valid
//   s_ready   out  loader accepts a byte this cycle
//   m_ce      out  port B enable (same as m_we)
//   m_we      out  port B write strobe, one cycle per word
//   m_addr    out  port B word address
//   m_write   out  port B write data
//   busy      out  load in progress
//   done      out  load completed successfully (sticky until next start)
//   error     out  frame error (sticky until next start)
//   cpu_hold  out  CPU reset request
// ---------------------------------------------------------------------------
module bootrom_stream_loader #(
  parameter int         DATA          = 32,
  parameter int         ADDR          = 12,
  parameter logic [7:0] MAGIC         = 8'h5A,
  parameter logic       HOLD_AT_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [7:0]      s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            m_ce,
  output logic            m_we,
  output logic [ADDR-1:0] m_addr,
  output logic [DATA-1:0] m_write,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            cpu_hold
);

  localparam int BYTES = DATA / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  // Word counter is wide enough to hold both the 16-bit length and 2**ADDR.
  localparam int CW    = (ADDR >= 16) ? (ADDR + 1) : 17;

  localparam logic [BW-1:0]   BYTE_ONE  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]   LAST_BYTE = BW'(BYTES - 1);
  localparam logic [ADDR-1:0] ADDR_ONE  = {{(ADDR-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   WORD_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   CAPACITY  = WORD_ONE << ADDR;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_MAGIC  = 4'd1;
  localparam logic [3:0] S_LEN_HI = 4'd2;
  localparam logic [3:0] S_LEN_LO = 4'd3;
  localparam logic [3:0] S_DATA   = 4'd4;
  localparam logic [3:0] S_FLUSH  = 4'd5;
  localparam logic [3:0] S_CSUM   = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  // Where a frame goes once its payload has been consumed.
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_END = S_CSUM;
`else
  localparam logic [3:0] S_END = S_DONE;
`endif

`ifdef LOADER_CHECKSUM_EN
  // Modulo-256 running sum used for the frame checksum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  logic [3:0]      state_q,    state_d;
  logic [15:0]     len_q,      len_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic [CW-1:0]   words_q,    words_d;
  logic [DATA-1:0] shift_q,    shift_d;
  logic [ADDR-1:0] m_addr_q,   m_addr_d;
  logic [DATA-1:0] m_write_q,  m_write_d;
  logic            m_we_q,     m_we_d;
  logic            s_ready_q,  s_ready_d;
  logic            busy_q,     busy_d;
  logic            done_q,     done_d;
  logic            error_q,    error_d;
  logic            cpu_hold_q, cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum_q,     csum_d;
`endif

  logic              xfer_s;
  logic [15:0]       full_len_s;
  logic [CW-1:0]     full_len_ext_s;
  logic [CW-1:0]     len_ext_s;
  logic [CW-1:0]     words_inc_s;
  logic              last_word_s;
  logic [DATA+7:0]   wide_s;
  logic [DATA-1:0]   shift_next_s;

  // Handshake, length and packing helpers shared by the next-state logic.
  always_comb begin
    xfer_s         = s_valid & s_ready_q;
    full_len_s     = {len_q[15:8], s_data};
    full_len_ext_s = {{(CW-16){1'b0}}, full_len_s};
    len_ext_s      = {{(CW-16){1'b0}}, len_q};
    words_inc_s    = words_q + WORD_ONE;
    last_word_s    = (words_inc_s == len_ext_s);
    // MSB-first packing: every new byte enters at the bottom and earlier
    // bytes move up, so byte 0 ends in the top lane after BYTES bytes.
    wide_s         = {shift_q, s_data};
    shift_next_s   = wide_s[DATA-1:0];
  end

  // Frame-parsing FSM and next values of all registered outputs.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    words_d    = words_q;
    shift_d    = shift_q;
    m_write_d  = m_write_q;
    m_we_d     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    // The address advances in the cycle after each strobe; the final word is
    // strobed from FLUSH so the address stays on the last written word.
    if (m_we_q && (state_q == S_DATA)) begin
      m_addr_d = m_addr_q + ADDR_ONE;
    end else begin
      m_addr_d = m_addr_q;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_MAGIC;
          m_addr_d   = {ADDR{1'b0}};
          byte_idx_d = {BW{1'b0}};
          words_d    = {CW{1'b0}};
`ifdef LOADER_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_MAGIC: begin
        // Anything other than the start byte is dropped silently (resync).
        if (xfer_s && (s_data == MAGIC)) begin
          state_d = S_LEN_HI;
        end else begin
          state_d = S_MAGIC;
        end
      end
      S_LEN_HI: begin
        if (xfer_s) begin
          len_d[15:8] = s_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d      = csum_add(csum_q, s_data);
`endif
          state_d     = S_LEN_LO;
        end else begin
          state_d = S_LEN_HI;
        end
      end
      S_LEN_LO: begin
        if (xfer_s) begin
          len_d = full_len_s;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_add(csum_q, s_data);
`endif
          if (full_len_s == 16'h0000) begin
            state_d = S_END;
          end else if (full_len_ext_s > CAPACITY) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_add(csum_q, s_data);
`endif
          shift_d = shift_next_s;
          if (byte_idx_q == LAST_BYTE) begin
            m_we_d     = 1'b1;
            m_write_d  = shift_next_s;
            byte_idx_d = {BW{1'b0}};
            words_d    = words_inc_s;
            if (last_word_s) begin
              state_d = S_FLUSH;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            byte_idx_d = byte_idx_q + BYTE_ONE;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_FLUSH: begin
        // Cycle carrying the last word's strobe; no byte is taken here.
        state_d = S_END;
      end
      S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer_s) begin
          if (csum_add(csum_q, s_data) == 8'h00) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CSUM;
        end
`else
        state_d = S_ERR;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs follow the state being entered, so they line up with
    // the state register on the next cycle.
    case (state_d)
      S_IDLE: begin
        s_ready_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        cpu_hold_d = cpu_hold_q;
      end
      S_DONE: begin
        s_ready_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        error_d    = 1'b0;
        cpu_hold_d = 1'b0;
      end
      S_ERR: begin
        s_ready_d  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b1;
        cpu_hold_d = 1'b1;
      end
      S_FLUSH: begin
        s_ready_d  = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        error_d    = 1'b0;
        cpu_hold_d = 1'b1;
      end
      default: begin
        s_ready_d  = 1'b1;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        error_d    = 1'b0;
        cpu_hold_d = 1'b1;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= 16'h0000;
      byte_idx_q <= {BW{1'b0}};
      words_q    <= {CW{1'b0}};
      shift_q    <= {DATA{1'b0}};
      m_addr_q   <= {ADDR{1'b0}};
      m_write_q  <= {DATA{1'b0}};
      m_we_q     <= 1'b0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cpu_hold_q <= HOLD_AT_RESET;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      words_q    <= words_d;
      shift_q    <= shift_d;
      m_addr_q   <= m_addr_d;
      m_write_q  <= m_write_d;
      m_we_q     <= m_we_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cpu_hold_q <= cpu_hold_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign s_ready  = s_ready_q;
  assign m_we     = m_we_q;
  assign m_ce     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_write  = m_write_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_bootrom_stream_loader.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for bootrom_stream_loader (default parameters).
// Stimulus pushes expected port-B writes into exp_q; a negedge monitor pops
// and compares each write the DUT strobes. Status outputs are checked inline.
// Honours LOADER_CHECKSUM_EN by appending hand-computed checksum bytes.
// ---------------------------------------------------------------------------
module tb_bootrom_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        m_ce;
  logic        m_we;
  logic [11:0] m_addr;
  logic [31:0] m_write;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;
  bit gaps   = 1'b0;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame_q[$];

  bootrom_stream_loader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_ce     (m_ce),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_write  (m_write),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (reset === 1'b0 && (m_we === 1'b1 || m_ce === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write", m_addr, m_write);
      end else begin
        e = exp_q.pop_front();
        if (m_ce !== m_we || m_addr !== e.addr || m_write !== e.data) begin
          errors++;
          $display("FAIL port_b_write: got ce %b we %b addr %h data %h, required ce 1 we 1 addr %h data %h",
                   m_ce, m_we, m_addr, m_write, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    guard   = 0;
    while (s_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got s_ready %b for byte %h, required 1", s_ready, b);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    frame_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called right after the last data byte (cycle t+1).
  task automatic end_frame(input logic [7:0] cs);
    chk("we_latency", {31'd0, m_we}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    chk("done_not_early", {31'd0, done}, 32'd0);
    @(negedge clk);
`endif
    chk("done_set", {31'd0, done}, 32'd1);
    chk("busy_clear", {31'd0, busy}, 32'd0);
    chk("cpu_released", {31'd0, cpu_hold}, 32'd0);
    chk("error_clear", {31'd0, error}, 32'd0);
  endtask

  task automatic load_frame1();
    exp_q.push_back('{12'h000, 32'hDEADBEEF});
    exp_q.push_back('{12'h001, 32'h01020304});
    frame_q = '{8'h5A, 8'h00, 8'h02, 8'hDE, 8'hAD};
    send_frame();
    pulse_start();  // busy: must be ignored
    frame_q = '{8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame();
    end_frame(8'hBC);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_addr", {20'd0, m_addr}, 32'd0);
    chk("rst_m_write", m_write, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Idle: bytes are refused.
    s_valid = 1'b1;
    s_data  = 8'h5A;
    @(negedge clk);
    chk("idle_refuses", {31'd0, s_ready}, 32'd0);
    s_valid = 1'b0;

    // Two-word image.
    pulse_start();
    chk("armed_busy", {31'd0, busy}, 32'd1);
    chk("armed_ready", {31'd0, s_ready}, 32'd1);
    load_frame1();

    // DONE refuses bytes and stays done.
    s_valid = 1'b1;
    @(negedge clk);
    chk("done_refuses", {31'd0, s_ready}, 32'd0);
    chk("done_sticky", {31'd0, done}, 32'd1);
    s_valid = 1'b0;

    // Leading junk is skipped.
    pulse_start();
    chk("restart_clears_done", {31'd0, done}, 32'd0);
    exp_q.push_back('{12'h000, 32'h11223344});
    frame_q = '{8'h00, 8'h13, 8'h5A, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame();
    end_frame(8'h55);

    // Zero length: no writes.
    pulse_start();
    frame_q = '{8'h5A, 8'h00, 8'h00};
    send_frame();
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    chk("zero_len_done", {31'd0, done}, 32'd1);
    chk("zero_len_release", {31'd0, cpu_hold}, 32'd0);

    // Oversized length 0x1001 > 4096.
    pulse_start();
    frame_q = '{8'h5A, 8'h10, 8'h01};
    send_frame();
    chk("oversize_error", {31'd0, error}, 32'd1);
    chk("oversize_hold", {31'd0, cpu_hold}, 32'd1);
    chk("oversize_busy", {31'd0, busy}, 32'd0);
    chk("oversize_ready", {31'd0, s_ready}, 32'd0);

    // Exactly 4096 words is legal; start while busy is ignored.
    pulse_start();
    chk("restart_clears_error", {31'd0, error}, 32'd0);
    frame_q = '{8'h5A, 8'h10, 8'h00};
    send_frame();
    chk("cap_len_no_error", {31'd0, error}, 32'd0);
    chk("cap_len_busy", {31'd0, busy}, 32'd1);
    pulse_start();
    exp_q.push_back('{12'h000, 32'hA1A2A3A4});
    frame_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
    send_frame();

    // Asynchronous reset during the third byte of word 1.
    s_data  = 8'hB3;
    s_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_ready", {31'd0, s_ready}, 32'd0);
    chk("async_m_addr", {20'd0, m_addr}, 32'd0);
    chk("async_m_write", m_write, 32'd0);
    chk("async_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Fresh image after reset, with random stream gaps.
    gaps = 1'b1;
    pulse_start();
    load_frame1();
    gaps = 1'b0;

    // Single word; checksum F5 good, F4 bad.
    pulse_start();
    exp_q.push_back('{12'h000, 32'h01020304});
    frame_q = '{8'h5A, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame();
    end_frame(8'hF5);
`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    exp_q.push_back('{12'h000, 32'h01020304});
    frame_q = '{8'h5A, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF4};
    send_frame();
    chk("bad_csum_error", {31'd0, error}, 32'd1);
    chk("bad_csum_hold", {31'd0, cpu_hold}, 32'd1);
    chk("bad_csum_done", {31'd0, done}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("leftover_writes", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
